// File: rtl/pc_pkg.sv
// Shared defaults and the redirect-cause encoding for the program-counter unit.
package pc_pkg;

  localparam int          DEF_XLEN      = 32;
  localparam int          DEF_NPH       = 5;
  localparam int          DEF_PH_F      = 0;
  localparam int          DEF_PH_W      = DEF_NPH - 1;
  localparam int          DEF_INC       = 4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
  localparam int          DEF_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_BR,
    RD_CALL,
    RD_RET,
    RD_SWAP,
    RD_TRAP
  } redirect_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
// A push into a full stack silently drops the oldest entry.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            swap,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [XLEN-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign top   = empty ? '0 : mem_q[ptr_q];

  // ptr_q always indexes the current top; a swap on an empty stack acts as a push.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push || (swap && empty)) begin
      ptr_d        = ptr_q + PW'(1);
      mem_d[ptr_d] = wdata;
      if (!full) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (swap) begin
      mem_d[ptr_q] = wdata;
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/pc_seq_ras.sv
// Phase-gated program counter with trap/return/call/branch redirect,
// exception PC capture and a circular return-address stack.
module pc_seq_ras
  import pc_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter int              NPH       = DEF_NPH,
  parameter int              PH_F      = DEF_PH_F,
  parameter int              PH_W      = NPH - 1,
  parameter int              INC       = DEF_INC,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NPH-1:0]  phase,
  input  logic            stall,
  input  logic            ct_taken,
  input  logic [XLEN-1:0] target,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            trap,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            do_fetch, do_wb;
  redirect_e       cause;
  logic            unused_phase;

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  assign unused_phase = ^phase;

  // Fetch wins when both phase bits are set; stall suppresses every update.
  assign do_fetch = phase[PH_F] && !stall;
  assign do_wb    = phase[PH_W] && !phase[PH_F] && !stall;

  always_comb begin
    cause = RD_NONE;
    if (do_wb) begin
      if (trap)                            cause = RD_TRAP;
      else if (ct_taken && is_ret && is_call) cause = RD_SWAP;
      else if (ct_taken && is_ret)         cause = RD_RET;
      else if (ct_taken && is_call)        cause = RD_CALL;
      else if (ct_taken)                   cause = RD_BR;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    if (rst) begin
      pc_d  = RESET_VEC;
      epc_d = '0;
    end else if (do_fetch) begin
      pc_d = pc_q + XLEN'(INC);
    end else begin
      unique case (cause)
        RD_TRAP: begin
          epc_d = pc_q;
          pc_d  = TRAP_VEC;
        end
        RD_SWAP, RD_RET: pc_d = align(ras_empty ? target : ras_top);
        RD_CALL, RD_BR:  pc_d = align(target);
        default:         pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    epc_q <= epc_d;
  end

  // The link pushed on a call is the PC already advanced during fetch.
  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (cause == RD_CALL),
    .pop   (cause == RD_RET),
    .swap  (cause == RD_SWAP),
    .wdata (pc_q),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign pc  = pc_q;
  assign epc = epc_q;

endmodule

// File: tb/tb_pc_seq_ras.sv
// Scoreboard bench for pc_seq_ras: directed scenarios followed by random traffic,
// every cycle checked against a queue-based reference model.
module tb_pc_seq_ras;

  localparam int          DEPTH = 4;
  localparam logic [4:0]  PF    = 5'b00001;
  localparam logic [4:0]  PWB   = 5'b10000;
  localparam logic [4:0]  PNONE = 5'b00000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] top;
    logic        empty;
    logic        full;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  phase = '0;
  logic        stall = 1'b0;
  logic        ct_taken = 1'b0;
  logic [31:0] target = '0;
  logic        is_call = 1'b0;
  logic        is_ret = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] pc, epc, ras_top;
  logic        ras_empty, ras_full;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  bit done = 1'b0;

  exp_t        sb[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_epc = '0;
  logic [31:0] m_ras[$];

  pc_seq_ras #(.RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .phase(phase), .stall(stall), .ct_taken(ct_taken),
    .target(target), .is_call(is_call), .is_ret(is_ret), .trap(trap),
    .pc(pc), .epc(epc), .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, got, want);
    end
  endtask

  // Reference model: the stack is a plain queue whose back is the top.
  task automatic modelStep();
    logic [31:0] nxt;
    if (rst) begin
      m_pc = 32'h0;
      m_epc = 32'h0;
      m_ras.delete();
    end else if (stall) begin
    end else if (phase[0]) begin
      m_pc = m_pc + 32'd4;
    end else if (phase[4]) begin
      if (trap) begin
        m_epc = m_pc;
        m_pc = 32'h100;
      end else if (ct_taken && is_ret && is_call) begin
        nxt = (m_ras.size() > 0) ? m_ras[$] : target;
        if (m_ras.size() > 0) m_ras[m_ras.size()-1] = m_pc;
        else m_ras.push_back(m_pc);
        m_pc = nxt & ~32'd3;
      end else if (ct_taken && is_ret) begin
        nxt = (m_ras.size() > 0) ? m_ras.pop_back() : target;
        m_pc = nxt & ~32'd3;
      end else if (ct_taken && is_call) begin
        m_ras.push_back(m_pc);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        m_pc = target & ~32'd3;
      end else if (ct_taken) begin
        m_pc = target & ~32'd3;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] ph, input logic st,
                               input logic ct, input logic [31:0] tg, input logic cl,
                               input logic rt, input logic tp);
    exp_t e;
    @(negedge clk);
    rst = r; phase = ph; stall = st; ct_taken = ct; target = tg;
    is_call = cl; is_ret = rt; trap = tp;
    @(posedge clk);
    #1;
    cycle++;
    modelStep();
    e.pc = m_pc;
    e.epc = m_epc;
    e.top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
    e.empty = (m_ras.size() == 0);
    e.full = (m_ras.size() == DEPTH);
    sb.push_back(e);
  endtask

  task automatic jump(input logic [31:0] tg);
    applyStimulus(0, PWB, 0, 1, tg, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per update and compares every output.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("sb_pc", pc, e.pc);
        checkOutput("sb_epc", epc, e.epc);
        checkOutput("sb_ras_top", ras_top, e.top);
        checkOutput("sb_ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
        checkOutput("sb_ras_full", {31'b0, ras_full}, {31'b0, e.full});
      end
    end
  end

  initial begin
    logic [4:0] ph;
    logic [31:0] tg;
    int r;

    applyStimulus(1, PNONE, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, PNONE, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, PF, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch_seq_pc", pc, 32'd20);
    checkOutput("fetch_seq_empty", {31'b0, ras_empty}, 32'd1);

    jump(32'h40);
    applyStimulus(0, PWB, 0, 1, 32'h203, 1, 0, 0);
    checkOutput("call_pc", pc, 32'h200);
    checkOutput("call_top", ras_top, 32'h40);
    applyStimulus(0, PWB, 0, 1, 32'h999, 0, 1, 0);
    checkOutput("ret_pc", pc, 32'h40);

    for (int i = 1; i <= 5; i++) begin
      jump(32'(i * 16));
      applyStimulus(0, PWB, 0, 1, 32'h300, 1, 0, 0);
    end
    checkOutput("ras_full", {31'b0, ras_full}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, PWB, 0, 1, 32'h700, 0, 1, 0);
      checkOutput("ret_chain_pc", pc, (i < 4) ? 32'(32'h50 - i * 16) : 32'h700);
    end

    jump(32'h88);
    applyStimulus(0, PWB, 0, 1, 32'h400, 1, 0, 1);
    checkOutput("trap_pc", pc, 32'h100);
    checkOutput("trap_epc", epc, 32'h88);
    applyStimulus(0, PF, 1, 0, 0, 0, 0, 0);
    checkOutput("stall_pc", pc, 32'h100);

    jump(32'hFFFF_FFFC);
    applyStimulus(0, PF, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_pc", pc, 32'h0);
    applyStimulus(0, PWB, 0, 1, 32'h500, 1, 0, 0);
    applyStimulus(1, PWB, 1, 1, 32'h600, 1, 0, 0);
    checkOutput("rst_stall_pc", pc, 32'h0);
    checkOutput("rst_stall_empty", {31'b0, ras_empty}, 32'd1);

    applyStimulus(0, PF | PWB, 0, 1, 32'h800, 0, 0, 0);
    checkOutput("fw_both_pc", pc, 32'h4);
    jump(32'h500);
    applyStimulus(0, PWB, 0, 1, 32'h60, 1, 0, 0);
    applyStimulus(0, PWB, 0, 1, 32'h900, 1, 1, 0);
    checkOutput("swap_pc", pc, 32'h500);
    checkOutput("swap_top", ras_top, 32'h60);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      ph = (r < 4) ? PF : (r < 8) ? PWB : (r == 8) ? (5'b00001 << $urandom_range(1, 3)) : (PF | PWB);
      tg = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      applyStimulus($urandom_range(0, 39) == 0, ph, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 4) != 0, tg, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    #3;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
